// File: rtl/rr_arb_mux_if.sv
// Bundles the arbiter's per-channel input handshake and its single registered output channel.
// Both sides use valid/ready: an item moves on a rising edge where valid and ready are both high;
// valid never waits for ready, and ready may depend combinationally on valid.
interface rr_arb_mux_if #(
   parameter int p_nbits   = 1,
   parameter int p_ninputs = 4,
   localparam int c_selbits = $clog2(p_ninputs)
);
   logic [p_ninputs-1:0]         in_val;
   logic [p_ninputs-1:0]         in_rdy;
   logic [p_ninputs*p_nbits-1:0] in_data;
   logic                         out_val;
   logic                         out_rdy;
   logic [p_nbits-1:0]           out_data;
   logic [c_selbits-1:0]         out_sel;

   modport master (
      output in_val, in_data, out_rdy,
      input  in_rdy, out_val, out_data, out_sel
   );

   modport slave (
      input  in_val, in_data, out_rdy,
      output in_rdy, out_val, out_data, out_sel
   );
endinterface

// File: rtl/rr_arb_mux.sv
// N-way arbiter feeding one output register; round-robin or fixed-priority grant,
// full throughput when the consumer keeps out_rdy high.
module rr_arb_mux #(
   parameter int p_nbits   = 1,
   parameter int p_ninputs = 4,
   parameter int p_rr      = 1,
   localparam int c_selbits = $clog2(p_ninputs)
) (
   input  logic                 clk,
   input  logic                 rst,
   rr_arb_mux_if.slave          bus,
   output logic [c_selbits-1:0] ptr_o
);

   localparam logic [c_selbits-1:0] c_one = 1;

   generate
      if (!(p_ninputs == 2 || p_ninputs == 4 || p_ninputs == 8)) begin : g_bad_ninputs
         $error("rr_arb_mux: p_ninputs must be 2, 4 or 8");
      end
      if (p_nbits < 1 || p_nbits > 64) begin : g_bad_nbits
         $error("rr_arb_mux: p_nbits must be 1..64");
      end
   endgenerate

   logic                 out_val_q, out_val_d;
   logic [p_nbits-1:0]   out_data_q, out_data_d;
   logic [c_selbits-1:0] out_sel_q, out_sel_d;
   logic [c_selbits-1:0] ptr_q, ptr_d;

   logic [p_ninputs-1:0] grant;
   logic [c_selbits-1:0] gnt_idx;
   logic [c_selbits-1:0] cand;
   logic                 found;
   logic [p_nbits-1:0]   data_mux;
   logic                 can_load;
   logic                 xfer;

   // Search starts at ptr and wraps naturally because p_ninputs is a power of two.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      cand    = '0;
      found   = 1'b0;
      for (int k = 0; k < p_ninputs; k++) begin
         cand = ptr_q + c_selbits'(k);
         if (!found && bus.in_val[cand]) begin
            found   = 1'b1;
            gnt_idx = cand;
         end
      end
      grant[gnt_idx] = found;
   end

   always_comb begin
      data_mux = '0;
      for (int i = 0; i < p_ninputs; i++) begin
         if (grant[i]) data_mux = bus.in_data[i*p_nbits +: p_nbits];
      end
   end

   assign can_load   = !out_val_q || bus.out_rdy;
   assign xfer       = found && can_load && !rst;
   assign bus.in_rdy = grant & {p_ninputs{can_load && !rst}};

   always_comb begin
      out_val_d  = out_val_q;
      out_data_d = out_data_q;
      out_sel_d  = out_sel_q;
      ptr_d      = ptr_q;
      if (xfer) begin
         out_val_d  = 1'b1;
         out_data_d = data_mux;
         out_sel_d  = gnt_idx;
         if (p_rr != 0) ptr_d = gnt_idx + c_one;
      end else if (bus.out_rdy) begin
         out_val_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_val_q  <= 1'b0;
         out_data_q <= '0;
         out_sel_q  <= '0;
         ptr_q      <= '0;
      end else begin
         out_val_q  <= out_val_d;
         out_data_q <= out_data_d;
         out_sel_q  <= out_sel_d;
         ptr_q      <= ptr_d;
      end
   end

   assign bus.out_val  = out_val_q;
   assign bus.out_data = out_data_q;
   assign bus.out_sel  = out_sel_q;
   assign ptr_o        = ptr_q;

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Parameters
REQ-001 SHALL have parameter p_nbits, default 1, data width in bits (legal 1..64).
REQ-002 SHALL have parameter p_ninputs, default 4, number of input channels (legal 2, 4, 8 only).
REQ-003 SHALL have parameter p_rr, default 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).
REQ-004 SHALL define c_selbits = clog2(p_ninputs).

Interface
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port in_val, input, p_ninputs, per-channel valid.
REQ-008 SHALL have port in_rdy, output, p_ninputs, per-channel ready (combinational).
REQ-009 SHALL have port in_data, input, p_ninputs*p_nbits, channel i at bits [i*p_nbits +: p_nbits].
REQ-010 SHALL have port out_val, output, 1, output register holds valid data.
REQ-011 SHALL have port out_rdy, input, 1, downstream accepts when out_val and out_rdy both high.
REQ-012 SHALL have port out_data, output, p_nbits, registered data of the winning channel.
REQ-013 SHALL have port out_sel, output, c_selbits, registered index of the channel that supplied out_data.

Function
REQ-014 SHALL contain one output register (out_val, out_data, out_sel) and one priority pointer ptr (c_selbits bits).
REQ-015 SHALL define can_load = !out_val || out_rdy (register empty or being drained this cycle).
REQ-016 SHALL compute grant combinationally: the first i with in_val[i]=1, searching from ptr upward modulo p_ninputs; at most one grant bit set.
REQ-017 SHALL drive in_rdy[i] = grant[i] && can_load && !rst; in_rdy is all-zero when no in_val is high.
REQ-018 SHALL treat a transfer on channel i as in_val[i] && in_rdy[i]; on a transfer, next cycle out_val=1, out_data=in_data[i], out_sel=i.
REQ-019 SHALL clear out_val next cycle when out_val && out_rdy and no transfer occurs.
REQ-020 SHALL hold out_val, out_data, out_sel unchanged while out_val=1 and out_rdy=0 (stall); no channel is granted ready.
REQ-021 SHALL support full throughput: simultaneous drain and load in one cycle, so one item per cycle with out_rdy held high.
REQ-022 SHALL have 1-cycle latency from input transfer to out_val.
REQ-023 SHALL, in round-robin mode, update ptr to (i+1) mod p_ninputs on a transfer from channel i; wrap from p_ninputs-1 to 0.
REQ-024 SHALL leave ptr unchanged in any cycle without a transfer (idle, stall, or no valid).
REQ-025 SHALL, in fixed mode (p_rr=0), keep ptr at 0 permanently.
REQ-026 SHALL not require in_data of non-granted channels to be stable; only the granted channel is sampled.

Reset
REQ-027 SHALL on rst=1 at a rising edge set out_val=0, out_data=0, out_sel=0, ptr=0, overriding any same-cycle transfer or drain.
REQ-028 SHALL hold in_rdy all-zero while rst=1; an item in the register when reset asserts is discarded.

Verification (p_nbits=8, p_ninputs=4, p_rr=1 unless noted)
REQ-029 SHALL check reset: rst=1 with in_val=4'b1111 -> in_rdy=0; after release out_val=0, out_data=0x00, out_sel=0.
REQ-030 SHALL check rotation: in_val=4'b1111 held, out_rdy=1, data ch i=0x10+i -> out_sel 0,1,2,3,0 on consecutive cycles, out_data 0x10,0x11,0x12,0x13,0x10, no bubbles.
REQ-031 SHALL check stall: load ch2=0xA5, out_rdy=0 for 3 cycles with in_val=4'b1011 -> out_data=0xA5, out_sel=2 held, in_rdy=0; out_rdy=1 -> next grant ch3.
REQ-032 SHALL check pointer skip and wrap: ptr=3 after a ch2 transfer, in_val=4'b0010 -> ch1 granted, next ptr=2.
REQ-033 SHALL check fixed mode (p_rr=0): in_val=4'b1100 held, out_rdy=1 -> out_sel=2 every cycle, ch3 never granted.
REQ-034 SHALL check mid-operation reset: out_val=1 with out_data=0x3C, rst pulsed one cycle -> out_val=0, ptr=0, first post-reset grant goes to the lowest valid index.
